// File: rtl/serial_word_feeder_pkg.sv
// Shared types and defaults for the serial word feeder.
//   feeder_state_t     : occupancy of the shifter / holding register pair
//   IDLE_LEVEL_DEFAULT : level driven on the serial line when no word is shifting
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL
    } feeder_state_t;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial stage feeding the "10110" pattern detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on j.
// A one-word holding register lets consecutive words stream with no gap bits.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   din        : parallel word, sampled only on accept
//   din_valid  : din holds a word to send
//   din_ready  : stage can accept a word this cycle (combinational)
//   j          : registered serial bit, IDLE_BIT when nothing is shifting
//   j_valid    : j carries a data bit
//   word_start : j carries the first bit of a word
//   busy       : shifter or holding register occupied
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             j,
    output logic             j_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    feeder_state_t    state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             j_d, j_valid_d, word_start_d;

    logic             accept;
    logic             last_bit;
    logic             load_en;
    logic             adv_en;
    logic [WIDTH-1:0] load_src;

    // Bit that goes out first from a word, depending on the configured order.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit consumed, so the next bit becomes the lead.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready depends only on hold occupancy so the source never sees a
    // combinational loop through din_valid.
    assign din_ready = (state_q != FULL) & ~rst;
    assign busy      = (state_q != IDLE);
    assign accept    = din_valid & din_ready;
    assign last_bit  = (cnt_q == LAST);

    // Next-state and datapath. cnt_q tracks the index of the bit currently on j,
    // so "last bit" means the final bit of the word is being driven right now and
    // the edge that ends this cycle decides what j carries next.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        j_d          = IDLE_BIT;
        j_valid_d    = 1'b0;
        word_start_d = 1'b0;
        load_en      = 1'b0;
        adv_en       = 1'b0;
        load_src     = din;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_en = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    adv_en = 1'b1;
                    if (accept) begin
                        hold_d  = din;
                        state_d = FULL;
                    end
                end else if (accept) begin
                    // Bypass the holding register so the new word follows with no gap.
                    load_en = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FULL: begin
                if (!last_bit) begin
                    adv_en = 1'b1;
                end else begin
                    load_en  = 1'b1;
                    load_src = hold_q;
                    state_d  = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            j_d          = lead_bit(load_src);
            shift_d      = advance(load_src);
            cnt_d        = '0;
            j_valid_d    = 1'b1;
            word_start_d = 1'b1;
        end else if (adv_en) begin
            j_d       = lead_bit(shift_q);
            shift_d   = advance(shift_q);
            cnt_d     = cnt_q + CW'(1);
            j_valid_d = 1'b1;
        end
    end

    // State and output registers; reset drops any word in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            cnt_q      <= '0;
            j          <= IDLE_BIT;
            j_valid    <= 1'b0;
            word_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            j          <= j_d;
            j_valid    <= j_valid_d;
            word_start <= word_start_d;
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed self-checking bench for serial_word_feeder (WIDTH=8).
// One MSB-first instance carries most scenarios; an LSB-first instance
// checks the alternate bit order.
module tb_serial_word_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       j;
    logic       j_valid;
    logic       word_start;
    logic       busy;

    logic [7:0] din_l;
    logic       din_valid_l;
    logic       din_ready_l;
    logic       j_l;
    logic       j_valid_l;
    logic       word_start_l;
    logic       busy_l;

    logic [4:0] hist = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .j(j), .j_valid(j_valid), .word_start(word_start), .busy(busy)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
        .j(j_l), .j_valid(j_valid_l), .word_start(word_start_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The last five bits the downstream detector would have sampled.
    always @(posedge clk) hist <= {hist[3:0], j};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; din = '0; din_valid = 1'b0; din_l = '0; din_valid_l = 1'b0;
        #3;
        n_cmp++; if (j !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_j: got %b want 0", j); end
        n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_j_valid: got %b want 0", j_valid); end
        n_cmp++; if (word_start !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_word_start: got %b want 0", word_start); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_din_ready: got %b want 0", din_ready); end
        tick;
        tick;
        rst = 1'b0;
        #1;
        n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_rst_ready: got %b want 1", din_ready); end
        for (int i = 0; i < 20; i++) begin
            tick;
            n_cmp++; if (j !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_j c%0d: got %b want 0", i, j); end
            n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_j_valid c%0d: got %b want 0", i, j_valid); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_busy c%0d: got %b want 0", i, busy); end
            n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL idle_ready c%0d: got %b want 1", i, din_ready); end
        end
    endtask

    task automatic test_single_word;
        logic [7:0] w;
        w = 8'hB0;
        din = w; din_valid = 1'b1;
        n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL single_ready: got %b want 1", din_ready); end
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (j !== w[7-i]) begin n_bad++; $display("[TB] FAIL single_j b%0d: got %b want %b", i, j, w[7-i]); end
            n_cmp++; if (j_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL single_j_valid b%0d: got %b want 1", i, j_valid); end
            n_cmp++; if (word_start !== (i == 0)) begin n_bad++; $display("[TB] FAIL single_word_start b%0d: got %b want %b", i, word_start, (i == 0)); end
            if (i == 5) begin
                n_cmp++; if (hist !== 5'b10110) begin n_bad++; $display("[TB] FAIL single_pattern: got %b want 10110", hist); end
            end
            tick;
        end
        n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL single_end_valid: got %b want 0", j_valid); end
        n_cmp++; if (j !== 1'b0) begin n_bad++; $display("[TB] FAIL single_end_j: got %b want 0", j); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3];
        logic [7:0] w;
        logic       acc;
        logic       exp_ready;
        int         idx;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        idx = 0;
        din = words[0]; din_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            acc = din_valid & din_ready;
            tick;
            if (acc) begin
                idx++;
                if (idx < 3) din = words[idx];
                else begin din = '0; din_valid = 1'b0; end
            end
            w = words[k/8];
            exp_ready = !((k >= 1 && k <= 7) || (k >= 9 && k <= 15));
            n_cmp++; if (j !== w[7 - (k % 8)]) begin n_bad++; $display("[TB] FAIL b2b_j k%0d: got %b want %b", k, j, w[7 - (k % 8)]); end
            n_cmp++; if (j_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_j_valid k%0d: got %b want 1", k, j_valid); end
            n_cmp++; if (word_start !== ((k % 8) == 0)) begin n_bad++; $display("[TB] FAIL b2b_word_start k%0d: got %b want %b", k, word_start, ((k % 8) == 0)); end
            n_cmp++; if (din_ready !== exp_ready) begin n_bad++; $display("[TB] FAIL b2b_ready k%0d: got %b want %b", k, din_ready, exp_ready); end
        end
        tick;
        n_cmp++; if (idx !== 3) begin n_bad++; $display("[TB] FAIL b2b_accepts: got %0d want 3", idx); end
        n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_end_valid: got %b want 0", j_valid); end
    endtask

    task automatic test_lsb_first;
        logic [7:0] w;
        w = 8'h0D;
        din_l = w; din_valid_l = 1'b1;
        tick;
        din_valid_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (j_l !== w[i]) begin n_bad++; $display("[TB] FAIL lsb_j b%0d: got %b want %b", i, j_l, w[i]); end
            n_cmp++; if (j_valid_l !== 1'b1) begin n_bad++; $display("[TB] FAIL lsb_j_valid b%0d: got %b want 1", i, j_valid_l); end
            n_cmp++; if (word_start_l !== (i == 0)) begin n_bad++; $display("[TB] FAIL lsb_word_start b%0d: got %b want %b", i, word_start_l, (i == 0)); end
            tick;
        end
        n_cmp++; if (j_valid_l !== 1'b0) begin n_bad++; $display("[TB] FAIL lsb_end_valid: got %b want 0", j_valid_l); end
        n_cmp++; if (busy_l !== 1'b0) begin n_bad++; $display("[TB] FAIL lsb_end_busy: got %b want 0", busy_l); end
    endtask

    task automatic test_reset_midword;
        logic [7:0] w;
        din = 8'hC3; din_valid = 1'b1;
        tick;
        din = 8'h5A;
        tick;
        din_valid = 1'b0; din = '0;
        tick; tick; tick;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_pre_busy: got %b want 1", busy); end
        n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_pre_ready: got %b want 0", din_ready); end
        n_cmp++; if (j !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_pre_j: got %b want 0", j); end
        rst = 1'b1;
        #1;
        n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_j_valid: got %b want 0", j_valid); end
        n_cmp++; if (j !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_j: got %b want 0", j); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_ready: got %b want 0", din_ready); end
        tick;
        rst = 1'b0;
        #1;
        n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_release_ready: got %b want 1", din_ready); end
        for (int i = 0; i < 10; i++) begin
            tick;
            n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_lost c%0d: got %b want 0", i, j_valid); end
        end
        w = 8'h96;
        din = w; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (j !== w[7-i]) begin n_bad++; $display("[TB] FAIL midrst_next_j b%0d: got %b want %b", i, j, w[7-i]); end
            n_cmp++; if (word_start !== (i == 0)) begin n_bad++; $display("[TB] FAIL midrst_next_ws b%0d: got %b want %b", i, word_start, (i == 0)); end
            tick;
        end
        n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_end_valid: got %b want 0", j_valid); end
    endtask

    task automatic test_bypass;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h81; b = 8'h7E;
        din = a; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_cmp++; if (j !== a[7-i]) begin n_bad++; $display("[TB] FAIL bypass_a_j b%0d: got %b want %b", i, j, a[7-i]); end
            tick;
        end
        n_cmp++; if (j !== a[0]) begin n_bad++; $display("[TB] FAIL bypass_a_last: got %b want %b", j, a[0]); end
        n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL bypass_ready: got %b want 1", din_ready); end
        din = b; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (j !== b[7-i]) begin n_bad++; $display("[TB] FAIL bypass_b_j b%0d: got %b want %b", i, j, b[7-i]); end
            n_cmp++; if (j_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL bypass_b_valid b%0d: got %b want 1", i, j_valid); end
            n_cmp++; if (word_start !== (i == 0)) begin n_bad++; $display("[TB] FAIL bypass_b_ws b%0d: got %b want %b", i, word_start, (i == 0)); end
            tick;
        end
        n_cmp++; if (j_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL bypass_end_valid: got %b want 0", j_valid); end
    endtask

    initial begin
        $display("[TB] serial_word_feeder directed tests");
        test_reset;
        test_single_word;
        test_back_to_back;
        test_lsb_first;
        test_reset_midword;
        test_bypass;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
